// File: rtl/load_data_unit.sv
// Load data unit: issues one word-aligned bus read per load, then extracts and
// sign/zero-extends the addressed byte, halfword or word for writeback.
module load_data_unit #(
  parameter int ADDR_W      = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [4:0]        req_rd,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic [ADDR_W-1:0] mem_araddr,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [31:0]       mem_rdata,
  input  logic [1:0]        mem_rresp,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [4:0]        resp_rd,
  output logic              resp_err
);

  typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;

  state_t            state_reg;
  logic [1:0]        off_reg;
  logic [2:0]        funct3_reg;
  logic [ADDR_W-1:0] araddr_reg;
  logic [31:0]       resp_data_reg;
  logic [4:0]        resp_rd_reg;
  logic              resp_err_reg;
  logic              req_bad;

  always_comb begin
    req_bad = 1'b0;
    case (req_funct3)
      3'b001, 3'b101: req_bad = req_addr[0];
      3'b010:         req_bad = (req_addr[1:0] != 2'b00);
      3'b011, 3'b110, 3'b111: req_bad = 1'b1;
      default:        req_bad = 1'b0;
    endcase
  end

  function automatic logic [31:0] extract(input logic [31:0] rdata,
                                          input logic [1:0]  off,
                                          input logic [2:0]  f3);
    logic [31:0] w;
    w = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  extract = {{24{w[7]}}, w[7:0]};
      3'b100:  extract = {24'd0, w[7:0]};
      3'b001:  extract = {{16{w[15]}}, w[15:0]};
      3'b101:  extract = {16'd0, w[15:0]};
      // LW and, with alignment checking off, undefined funct3 codes return the shifted word
      default: extract = w;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      off_reg       <= 2'b00;
      funct3_reg    <= 3'b000;
      araddr_reg    <= '0;
      resp_data_reg <= 32'd0;
      resp_rd_reg   <= 5'd0;
      resp_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            off_reg     <= req_addr[1:0];
            funct3_reg  <= req_funct3;
            resp_rd_reg <= req_rd;
            araddr_reg  <= {req_addr[ADDR_W-1:2], 2'b00};
            if (CHECK_ALIGN && req_bad) begin
              resp_data_reg <= 32'd0;
              resp_err_reg  <= 1'b1;
              state_reg     <= RESP;
            end else begin
              state_reg <= AR;
            end
          end
        end
        AR: begin
          if (mem_arready) state_reg <= R;
        end
        R: begin
          if (mem_rvalid) begin
            resp_data_reg <= extract(mem_rdata, off_reg, funct3_reg);
            resp_err_reg  <= (mem_rresp != 2'b00);
            state_reg     <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready   = (state_reg == IDLE);
  assign mem_arvalid = (state_reg == AR);
  assign mem_rready  = (state_reg == R);
  assign resp_valid  = (state_reg == RESP);
  assign mem_araddr  = araddr_reg;
  assign resp_data   = resp_data_reg;
  assign resp_rd     = resp_rd_reg;
  assign resp_err    = resp_err_reg;

endmodule

// File: tb/tb_load_data_unit.sv
// Randomized and directed bench for load_data_unit against an arithmetic model
// of RISC-V load extraction, alignment rules and handshake timing.
module tb_load_data_unit;

  localparam bit CHECK_ALIGN = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_arvalid;
  logic        mem_arready = 1'b0;
  logic [31:0] mem_araddr;
  logic        mem_rvalid = 1'b0;
  logic        mem_rready;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  mem_rresp = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;

  int vectors = 0;
  int miscompares = 0;
  int ar_hs = 0;
  int arvalid_cycles = 0;
  int txn = 0;

  load_data_unit #(.ADDR_W(32), .CHECK_ALIGN(CHECK_ALIGN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_rd(req_rd),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
    .mem_rresp(mem_rresp),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && mem_arvalid && mem_arready) ar_hs++;
    if (mem_arvalid) arvalid_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: what a load returns, computed from byte offsets with plain arithmetic.
  function automatic void model(input logic [31:0] addr, input logic [2:0] f3,
                                input logic [31:0] rdata, input logic [1:0] rresp,
                                output logic [31:0] data, output logic err,
                                output logic bad);
    int unsigned off, shifted, v;
    off     = addr % 4;
    shifted = rdata >> (8 * off);
    bad = CHECK_ALIGN && (((f3 == 1 || f3 == 5) && (off % 2 != 0)) ||
                          (f3 == 2 && off != 0) || f3 == 3 || f3 == 6 || f3 == 7);
    case (f3)
      3'd0: begin v = shifted % 256;   data = (v >= 128)   ? v - 256   : v; end
      3'd4: data = shifted % 256;
      3'd1: begin v = shifted % 65536; data = (v >= 32768) ? v - 65536 : v; end
      3'd5: data = shifted % 65536;
      default: data = shifted;
    endcase
    err = (rresp != 0);
    if (bad) begin
      data = 0;
      err  = 1'b1;
    end
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_arvalid"}, 32'(mem_arvalid), 32'd0);
    check({tag, "_rready"}, 32'(mem_rready), 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic run_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic [1:0] rresp,
                          input int ar_d, input int r_d, input int resp_d);
    logic [31:0] exp_data;
    logic exp_err, bad;
    int hs0, av0;
    model(addr, f3, rdata, rresp, exp_data, exp_err, bad);
    hs0 = ar_hs;
    av0 = arvalid_cycles;
    @(negedge clk);
    check("accept_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = addr; req_funct3 = f3; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_funct3 = 3'($urandom); req_rd = 5'($urandom);
    if (!bad) begin
      for (int i = 0; i < ar_d; i++) begin
        check("ar_wait_arvalid", 32'(mem_arvalid), 32'd1);
        check("ar_wait_araddr", mem_araddr, addr & 32'hFFFF_FFFC);
        check("ar_wait_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
      end
      check("arvalid", 32'(mem_arvalid), 32'd1);
      check("araddr", mem_araddr, addr & 32'hFFFF_FFFC);
      mem_arready = 1'b1;
      @(negedge clk);
      mem_arready = 1'b0;
      check("r_arvalid_low", 32'(mem_arvalid), 32'd0);
      for (int i = 0; i < r_d; i++) begin
        check("r_wait_rready", 32'(mem_rready), 32'd1);
        check("r_wait_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
      end
      check("rready", 32'(mem_rready), 32'd1);
      mem_rvalid = 1'b1; mem_rdata = rdata; mem_rresp = rresp;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = $urandom; mem_rresp = 2'($urandom);
    end
    for (int i = 0; i <= resp_d; i++) begin
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_arvalid_low", 32'(mem_arvalid), 32'd0);
      check("resp_req_ready", 32'(req_ready), 32'd0);
      check("resp_data", resp_data, exp_data);
      check("resp_rd", 32'(resp_rd), 32'(rd));
      check("resp_err", 32'(resp_err), 32'(exp_err));
      if (i < resp_d) begin
        mem_rdata = $urandom;
        @(negedge clk);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_idle("post_resp");
    check("bus_transactions", 32'(ar_hs - hs0), bad ? 32'd0 : 32'd1);
    if (bad) check("bad_no_arvalid", 32'(arvalid_cycles - av0), 32'd0);
    txn++;
    $display("txn %0d f3=%0d addr=%h rd=%0d rdata=%h rresp=%0d -> data=%h err=%0b (exp %h/%0b)",
             txn, f3, addr, rd, rdata, rresp, resp_data, resp_err, exp_data, exp_err);
  endtask

  // Drive a load up to the given state (1=AR, 2=R, 3=RESP), then reset mid-flight.
  task automatic reset_in(input int stage);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_0040; req_funct3 = 3'b010; req_rd = 5'd9;
    @(negedge clk);
    req_valid = 1'b0;
    if (stage >= 2) begin
      mem_arready = 1'b1; @(negedge clk); mem_arready = 1'b0;
    end
    if (stage >= 3) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; mem_rresp = 2'b00;
      @(negedge clk);
      mem_rvalid = 1'b0;
    end
    case (stage)
      1: check("pre_rst_arvalid", 32'(mem_arvalid), 32'd1);
      2: check("pre_rst_rready", 32'(mem_rready), 32'd1);
      default: check("pre_rst_resp_valid", 32'(resp_valid), 32'd1);
    endcase
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("after_rst");
    check("after_rst_resp_data", resp_data, 32'd0);
    check("after_rst_resp_rd", 32'(resp_rd), 32'd0);
    check("after_rst_resp_err", 32'(resp_err), 32'd0);
    check("after_rst_araddr", mem_araddr, 32'd0);
    $display("reset applied in stage %0d", stage);
    run_load(32'h0000_2001 + 32'(stage), 3'b000, 5'd7, 32'h1122_8344, 2'b00, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");
    check("reset_resp_data", resp_data, 32'd0);
    check("reset_resp_rd", 32'(resp_rd), 32'd0);
    check("reset_resp_err", 32'(resp_err), 32'd0);
    check("reset_araddr", mem_araddr, 32'd0);

    run_load(32'h8000_0003, 3'b000, 5'd17, 32'h80FF_1234, 2'b00, 0, 0, 0);
    run_load(32'h0000_1002, 3'b101, 5'd3,  32'hBEEF_0000, 2'b00, 0, 0, 0);
    run_load(32'h0000_1002, 3'b001, 5'd4,  32'hBEEF_0000, 2'b00, 0, 0, 0);
    run_load(32'h0000_1000, 3'b010, 5'd5,  32'h1234_5678, 2'b00, 0, 0, 0);
    run_load(32'h0000_1001, 3'b010, 5'd6,  32'h1234_5678, 2'b00, 0, 0, 0);
    run_load(32'h0000_1000, 3'b011, 5'd8,  32'h1234_5678, 2'b00, 0, 0, 0);
    run_load(32'h0000_2003, 3'b001, 5'd10, 32'hAABB_CCDD, 2'b00, 0, 0, 2);
    run_load(32'h0000_3005, 3'b000, 5'd11, 32'h0000_7F00, 2'b00, 3, 5, 4);
    run_load(32'h0000_4001, 3'b100, 5'd12, 32'h0000_F100, 2'b10, 0, 1, 1);

    reset_in(1);
    reset_in(2);
    reset_in(3);

    for (int n = 0; n < 60; n++) begin
      run_load($urandom, 3'($urandom_range(0, 7)), 5'($urandom), $urandom,
               ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
